// File: rtl/bcd_disp_pkg.sv
// Shared types and constants for the two-digit multiplexed 7-segment display.
// Segment codes are active-low, bit order {g,f,e,d,c,b,a}.
package bcd_disp_pkg;

    typedef enum logic [1:0] {
        ONES_BLANK = 2'd0,
        ONES_ON    = 2'd1,
        TENS_BLANK = 2'd2,
        TENS_ON    = 2'd3
    } scan_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // Entry [n] is the active-low pattern for digit n.
    localparam logic [9:0][6:0] SEG_CODES = {
        7'h10,  // 9
        7'h00,  // 8
        7'h78,  // 7
        7'h02,  // 6
        7'h12,  // 5
        7'h19,  // 4
        7'h30,  // 3
        7'h24,  // 2
        7'h79,  // 1
        7'h40   // 0
    };

endpackage

// File: rtl/bcd_display_scan_seg7_decode.sv
// BCD to active-low 7-segment decoder. Non-BCD inputs (>9) show a dash.
module seg7_decode
    import bcd_disp_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg_n
);

    // Table lookup for valid digits, dash for anything out of range
    always_comb begin
        seg_n = SEG_DASH;
        if (bcd <= 4'd9) begin
            seg_n = SEG_CODES[bcd];
        end
    end

endmodule

// File: rtl/bcd_display_scan.sv
// Two-digit common-anode 7-segment scanner fed by a BCD counter.
// Digits are captured into a pending register on `load` and promoted to the
// display register only at the frame boundary, so a frame never mixes old and
// new digits. Each lit slot is preceded by an all-anodes-off guard gap.
//
// Build option: LEADING_ZERO_BLANK_EN - when defined, a tens digit of 0 is
// left dark during its slot (timing and frame_tick unchanged).
//
// state      | meaning
// -----------+---------------------------------------------
// ONES_BLANK | guard gap before ones digit, anodes off
// ONES_ON    | ones digit lit (an_n=10)
// TENS_BLANK | guard gap before tens digit, anodes off
// TENS_ON    | tens digit lit (an_n=01); last cycle = frame end
module bcd_display_scan
    import bcd_disp_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] ones,
    input  logic [3:0] tens,
    input  logic       load,
    output logic [1:0] an_n,
    output logic [6:0] seg_n,
    output logic       frame_tick
);

    localparam int MAX_LEN = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
    localparam int CW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [CW-1:0] SCAN_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    scan_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          slot_last;
    logic          frame_end;

    logic [3:0]    pend_ones_q, pend_tens_q;
    logic [3:0]    disp_ones_q, disp_tens_q;

    logic [3:0]    dig_sel;
    logic [6:0]    dig_seg_n;

    logic [1:0]    an_d;
    logic [6:0]    seg_d;
    logic          tick_d;

    // Slot sequencing: count through the current slot, then advance in fixed order
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CW'(1);
        slot_last = 1'b0;
        case (state_q)
            ONES_ON, TENS_ON: slot_last = (cnt_q == SCAN_LAST);
            default:          slot_last = (cnt_q == BLANK_LAST);
        endcase
        if (slot_last) begin
            cnt_d = '0;
            case (state_q)
                ONES_BLANK: state_d = ONES_ON;
                ONES_ON:    state_d = TENS_BLANK;
                TENS_BLANK: state_d = TENS_ON;
                default:    state_d = ONES_BLANK;
            endcase
        end
    end

    assign frame_end = (state_q == TENS_ON) && slot_last;

    // The display register only changes entering ONES_BLANK, so by the time a
    // lit slot is entered the current display value is already the right one.
    assign dig_sel = (state_d == TENS_ON) ? disp_tens_q : disp_ones_q;

    seg7_decode u_seg7_decode (
        .bcd   (dig_sel),
        .seg_n (dig_seg_n)
    );

    // Next-cycle outputs, derived from the next state so they change on the
    // same edge as the state register
    always_comb begin
        an_d   = 2'b11;
        seg_d  = SEG_BLANK;
        tick_d = (state_d == TENS_ON) && (cnt_d == SCAN_LAST);
        case (state_d)
            ONES_ON: begin
                an_d  = 2'b10;
                seg_d = dig_seg_n;
            end
            TENS_ON: begin
`ifdef LEADING_ZERO_BLANK_EN
                if (disp_tens_q != 4'd0) begin
                    an_d  = 2'b01;
                    seg_d = dig_seg_n;
                end
`else
                an_d  = 2'b01;
                seg_d = dig_seg_n;
`endif
            end
            default: begin
                an_d  = 2'b11;
                seg_d = SEG_BLANK;
            end
        endcase
    end

    // State and slot counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ONES_BLANK;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Pending digits: any load overwrites, last one before the boundary wins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_ones_q <= 4'd0;
            pend_tens_q <= 4'd0;
        end else if (load) begin
            pend_ones_q <= ones;
            pend_tens_q <= tens;
        end
    end

    // Displayed digits: promoted from pending at the frame boundary only; a
    // load on that same edge is not seen here until the following frame
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            disp_ones_q <= 4'd0;
            disp_tens_q <= 4'd0;
        end else if (frame_end) begin
            disp_ones_q <= pend_ones_q;
            disp_tens_q <= pend_tens_q;
        end
    end

    // Registered pin drivers, forced dark immediately on reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            an_n       <= 2'b11;
            seg_n      <= SEG_BLANK;
            frame_tick <= 1'b0;
        end else begin
            an_n       <= an_d;
            seg_n      <= seg_d;
            frame_tick <= tick_d;
        end
    end

endmodule

// File: tb/tb_bcd_display_scan.sv
// Scoreboard bench for bcd_display_scan with SCAN_DIV=8, BLANK_CYCLES=2.
module tb_bcd_display_scan;

    localparam int SCAN_DIV     = 8;
    localparam int BLANK_CYCLES = 2;
    localparam int FRAME        = 2 * (SCAN_DIV + BLANK_CYCLES);

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] ones = 4'd0;
    logic [3:0] tens = 4'd0;
    logic       load = 1'b0;
    logic [1:0] an_n;
    logic [6:0] seg_n;
    logic       frame_tick;

    int n_checks = 0;
    int n_fail   = 0;

    logic [9:0] exp_q[$];
    logic       mon_en = 1'b0;

    bcd_display_scan #(
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ones       (ones),
        .tens       (tens),
        .load       (load),
        .an_n       (an_n),
        .seg_n      (seg_n),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] exp_code(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    // Push expected {an_n, seg_n, frame_tick} for the first npos cycles of a frame
    task automatic push_frame(input logic [3:0] o, input logic [3:0] t, input int npos);
        logic [1:0] an;
        logic [6:0] sg;
        logic       tk;
        for (int p = 0; p < npos; p++) begin
            an = 2'b11;
            sg = 7'h7F;
            tk = (p == FRAME - 1);
            if (p >= BLANK_CYCLES && p < BLANK_CYCLES + SCAN_DIV) begin
                an = 2'b10;
                sg = exp_code(o);
            end else if (p >= 2 * BLANK_CYCLES + SCAN_DIV) begin
                an = 2'b01;
                sg = exp_code(t);
`ifdef LEADING_ZERO_BLANK_EN
                if (t == 4'd0) begin
                    an = 2'b11;
                    sg = 7'h7F;
                end
`endif
            end
            exp_q.push_back({an, sg, tk});
        end
    endtask

    task automatic check_reset_state(input string name);
        n_checks++;
        if (an_n !== 2'b11 || seg_n !== 7'h7F || frame_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: got an_n=%b seg_n=%h tick=%b, want an_n=11 seg_n=7f tick=0",
                     name, an_n, seg_n, frame_tick);
        end
    endtask

    // Monitor: one scoreboard entry per cycle, plus frame_tick spacing
    int   mcyc = 0;
    int   last_tick = 0;
    logic have_tick = 1'b0;
    always @(negedge clk) begin
        logic [9:0] e;
        if (!mon_en) begin
            have_tick = 1'b0;
            mcyc      = 0;
        end else begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if ({an_n, seg_n, frame_tick} !== e) begin
                    n_fail++;
                    $display("FAIL scan cyc=%0d: got an_n=%b seg_n=%h tick=%b, want an_n=%b seg_n=%h tick=%b",
                             mcyc, an_n, seg_n, frame_tick, e[9:8], e[7:1], e[0]);
                end
            end
            if (frame_tick === 1'b1) begin
                if (have_tick) begin
                    n_checks++;
                    if (mcyc - last_tick != FRAME) begin
                        n_fail++;
                        $display("FAIL tick_gap cyc=%0d: got %0d, want %0d",
                                 mcyc, mcyc - last_tick, FRAME);
                    end
                end
                have_tick = 1'b1;
                last_tick = mcyc;
            end
            mcyc++;
        end
    end

    task automatic do_load(input logic [3:0] t, input logic [3:0] o);
        tens = t;
        ones = o;
        load = 1'b1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        check_reset_state("reset_initial");

        // Frames 0..4 and the first 16 cycles of frame 5
        push_frame(4'd0, 4'd0, FRAME);   // F0: no load yet
        push_frame(4'd2, 4'd4, FRAME);   // F1: 42 loaded during F0
        push_frame(4'd5, 4'd5, FRAME);   // F2: 37 then 55 in F1, 55 wins
        push_frame(4'd5, 4'd5, FRAME);   // F3: load on the boundary edge not yet shown
        push_frame(4'hC, 4'd9, FRAME);   // F4: dash / 9
        push_frame(4'hC, 4'd9, 16);      // F5: interrupted by reset mid TENS_ON
        reset_n = 1'b1;
        mon_en  = 1'b1;

        for (int c = 0; c <= 115; c++) begin
            @(negedge clk);
            load = 1'b0;
            case (c)
                5:  do_load(4'd4, 4'd2);
                23: do_load(4'd3, 4'd7);
                30: do_load(4'd5, 4'd5);
                59: do_load(4'd9, 4'hC);
                default: ;
            endcase
        end

        #2;
        reset_n = 1'b0;
        mon_en  = 1'b0;
        #1;
        check_reset_state("reset_mid_tens_on");
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_before_reset: got %0d entries left, want 0", exp_q.size());
        end

        repeat (3) @(posedge clk);
        #2;
        check_reset_state("reset_held");
        exp_q.delete();
        push_frame(4'd0, 4'd0, FRAME);   // restart shows 00
        push_frame(4'd7, 4'd0, FRAME);   // 07 loaded during restart frame
        reset_n = 1'b1;
        mon_en  = 1'b1;

        for (int c = 0; c <= 2 * FRAME; c++) begin
            @(negedge clk);
            load = 1'b0;
            if (c == 4) do_load(4'd0, 4'd7);
        end
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: got %0d entries left, want 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog
    initial begin
        #20000;
        $display("FAIL watchdog: got timeout, want normal completion");
        $fatal(1, "timeout");
    end

endmodule
